inst_decode_stage: RTL and testbench

//  Decode stage directly downstream of the instruction-fetch block; consumes its 32-bit inst.

---
 rtl/inst_decode_stage.sv | 82 ++++++++
 tb/tb_inst_decode_stage.sv | 85 ++++++++
 2 files changed

// File: rtl/inst_decode_stage.sv
// inst_decode_stage: IF/ID register with MIPS field decode, immediate extension, type flags and a 2R1W register file.
// Define REGFILE_BYPASS_EN to make same-cycle write-back data visible on rs_data/rt_data (write-through).
module inst_decode_stage #(
  parameter int          DATA_W     = 32,
  parameter int          REG_AW     = 5,
  parameter logic [31:0] RESET_INST = 32'h00000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [31:0]       inst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              valid,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [DATA_W-1:0] imm_ext,
  output logic [25:0]       jaddr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              is_rtype,
  output logic              is_load,
  output logic              is_store,
  output logic              is_branch,
  output logic              is_jump
);
  logic [31:0]       inst_q, inst_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rf_q [2**REG_AW];
  logic [DATA_W-1:0] rf_d [2**REG_AW];
  logic [REG_AW-1:0] rs_a, rt_a;
  logic              zext;
  always_comb begin
    inst_d  = flush ? RESET_INST : enable ? inst : inst_q;
    valid_d = flush ? 1'b0 : enable ? 1'b1 : valid_q;
    rf_d = rf_q;
    if (wb_we && wb_addr != '0) rf_d[wb_addr] = wb_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q  <= RESET_INST;
      valid_q <= 1'b0;
      rf_q    <= '{default: '0};
    end else begin
      inst_q  <= inst_d;
      valid_q <= valid_d;
      rf_q    <= rf_d;
    end
  end
  always_comb begin
    valid     = valid_q;
    opcode    = inst_q[31:26];
    rs        = inst_q[25:21];
    rt        = inst_q[20:16];
    rd        = inst_q[15:11];
    shamt     = inst_q[10:6];
    funct     = inst_q[5:0];
    jaddr     = inst_q[25:0];
    zext      = opcode inside {6'h0C, 6'h0D, 6'h0E};
    imm_ext   = {{(DATA_W-16){inst_q[15] & ~zext}}, inst_q[15:0]};
    is_rtype  = valid_q && opcode == 6'h00;
    is_load   = valid_q && opcode == 6'h23;
    is_store  = valid_q && opcode == 6'h2B;
    is_branch = valid_q && (opcode == 6'h04 || opcode == 6'h05);
    is_jump   = valid_q && (opcode == 6'h02 || opcode == 6'h03);
    rs_a      = REG_AW'(rs);
    rt_a      = REG_AW'(rt);
`ifdef REGFILE_BYPASS_EN
    rs_data = (wb_we && wb_addr != '0 && wb_addr == rs_a) ? wb_data : rf_q[rs_a];
    rt_data = (wb_we && wb_addr != '0 && wb_addr == rt_a) ? wb_data : rf_q[rt_a];
`else
    rs_data = rf_q[rs_a];
    rt_data = rf_q[rt_a];
`endif
  end
endmodule

// File: tb/tb_inst_decode_stage.sv
// tb_inst_decode_stage: directed vectors; each cycle's hand-computed expectation is queued and checked mid-cycle by a monitor.
module tb_inst_decode_stage;
  logic        clk = 0, reset = 1, enable = 0, flush = 0, wb_we = 0;
  logic [31:0] inst = 0, wb_data = 0;
  logic [4:0]  wb_addr = 0;
  logic        valid, is_rtype, is_load, is_store, is_branch, is_jump;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_ext, rs_data, rt_data;
  logic [25:0] jaddr;
  int          n = 0, errs = 0;
  typedef struct {logic v; logic [31:0] i, imm, rsd, rtd; logic [4:0] fl;} exp_t;
  exp_t sb[$];
  inst_decode_stage dut (
    .clk(clk), .reset(reset), .enable(enable), .flush(flush), .inst(inst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .valid(valid),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm_ext(imm_ext), .jaddr(jaddr), .rs_data(rs_data), .rt_data(rt_data),
    .is_rtype(is_rtype), .is_load(is_load), .is_store(is_store),
    .is_branch(is_branch), .is_jump(is_jump)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, a, e, $time);
    end
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("valid", 32'(valid), 32'(e.v));
      chk("fields", {opcode, rs, rt, rd, shamt, funct}, e.i);
      chk("jaddr", 32'(jaddr), {6'd0, e.i[25:0]});
      chk("imm_ext", imm_ext, e.imm);
      chk("rs_data", rs_data, e.rsd);
      chk("rt_data", rt_data, e.rtd);
      chk("flags", 32'({is_rtype, is_load, is_store, is_branch, is_jump}), 32'(e.fl));
    end
  // Drive inputs for the next edge; expectation describes what is visible during this cycle.
  task automatic cyc(input logic r, en, fl, input logic [31:0] in, input logic we,
                     input logic [4:0] wa, input logic [31:0] wd, input logic ev,
                     input logic [31:0] ei, eimm, ers, ert, input logic [4:0] efl);
    @(posedge clk);
    #2;
    reset = r; enable = en; flush = fl; inst = in; wb_we = we; wb_addr = wa; wb_data = wd;
    sb.push_back('{ev, ei, eimm, ers, ert, efl});
  endtask
  localparam logic [31:0] BYP = 
`ifdef REGFILE_BYPASS_EN
    32'hA5A5A5A5;
`else
    32'hDEADBEEF;
`endif
  initial begin
    repeat (2) @(posedge clk);
    //   rst en fl inst          we wa  wd            v  exp_inst      imm           rs_data       rt_data       flags
    cyc(1, 0, 0, 32'h0,        0, 0,  32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        5'b00000);
    cyc(0, 0, 0, 32'h0,        1, 5,  32'hDEADBEEF, 0, 32'h0,        32'h0,        32'h0,        32'h0,        5'b00000);
    cyc(0, 1, 0, 32'h00A63020, 0, 0,  32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        5'b00000);
    cyc(0, 1, 0, 32'h2001FFFF, 0, 0,  32'h0,        1, 32'h00A63020, 32'h00003020, 32'hDEADBEEF, 32'h0,        5'b10000);
    cyc(0, 1, 0, 32'h3401FFFF, 0, 0,  32'h0,        1, 32'h2001FFFF, 32'hFFFFFFFF, 32'h0,        32'h0,        5'b00000);
    cyc(0, 1, 0, 32'h8CA20004, 1, 0,  32'h1234,     1, 32'h3401FFFF, 32'h0000FFFF, 32'h0,        32'h0,        5'b00000);
    cyc(0, 1, 0, 32'hAC060008, 0, 0,  32'h0,        1, 32'h8CA20004, 32'h00000004, 32'hDEADBEEF, 32'h0,        5'b01000);
    cyc(0, 0, 0, 32'h10A6FFFE, 0, 0,  32'h0,        1, 32'hAC060008, 32'h00000008, 32'h0,        32'h0,        5'b00100);
    cyc(0, 0, 0, 32'h0BADF00D, 0, 0,  32'h0,        1, 32'hAC060008, 32'h00000008, 32'h0,        32'h0,        5'b00100);
    cyc(0, 1, 0, 32'h10A6FFFE, 0, 0,  32'h0,        1, 32'hAC060008, 32'h00000008, 32'h0,        32'h0,        5'b00100);
    cyc(0, 1, 1, 32'h0C000010, 0, 0,  32'h0,        1, 32'h10A6FFFE, 32'hFFFFFFFE, 32'hDEADBEEF, 32'h0,        5'b00010);
    cyc(0, 1, 0, 32'h0C000010, 0, 0,  32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        5'b00000);
    cyc(0, 1, 0, 32'h00A00008, 0, 0,  32'h0,        1, 32'h0C000010, 32'h00000010, 32'h0,        32'h0,        5'b00001);
    cyc(0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 32'h00A00008, 32'h00000008, 32'hDEADBEEF, 32'h0,        5'b10000);
    cyc(0, 0, 0, 32'h0,        1, 5,  32'hA5A5A5A5, 1, 32'h00A00008, 32'h00000008, BYP,          32'h0,        5'b10000);
    cyc(0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 32'h00A00008, 32'h00000008, 32'hA5A5A5A5, 32'h0,        5'b10000);
    cyc(1, 1, 0, 32'h8CE70000, 1, 7,  32'hFFFFFFFF, 1, 32'h00A00008, 32'h00000008, 32'hA5A5A5A5, 32'h0,        5'b10000);
    cyc(0, 1, 0, 32'h8CE70000, 0, 0,  32'h0,        0, 32'h0,        32'h0,        32'h0,        32'h0,        5'b00000);
    cyc(0, 0, 0, 32'h0,        0, 0,  32'h0,        1, 32'h8CE70000, 32'h0,        32'h0,        32'h0,        5'b01000);
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0) chk("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
